// File: rtl/spi_flash_reader.sv
// SPI mode-0 burst reader for a serial NOR flash.
// Issues READ (0x03) plus a 24-bit address, then streams the requested number of bytes
// back to the requester as single-cycle data_valid strobes. flash_clk runs at clk/2,
// idles low, and only toggles while flash_cs_n is low.
module spi_flash_reader #(
  parameter int unsigned LENGTH_BITWIDTH = 8,
  parameter int unsigned CS_HIGH_CYCLES  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [23:0]                address,
  input  logic [LENGTH_BITWIDTH-1:0] length,
  output logic                       busy,
  output logic [7:0]                 data_out,
  output logic                       data_valid,
  output logic                       done,
  output logic                       flash_clk,
  output logic                       flash_mosi,
  input  logic                       flash_miso,
  output logic                       flash_cs_n
);

  localparam logic [7:0] CmdRead = 8'h03;
  localparam int unsigned TailW = (CS_HIGH_CYCLES > 1) ? $clog2(CS_HIGH_CYCLES) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StData,
    StTail
  } state_e;

  state_e                     state_q, state_d;
  // Outgoing command/address bits still to send; the next bit is always at [31].
  logic [31:0]                shift_q, shift_d;
  // Bits left in the current section (cmd, addr or data byte), minus one.
  logic [4:0]                 bit_cnt_q, bit_cnt_d;
  logic [LENGTH_BITWIDTH-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]                 rx_q, rx_d;
  logic [TailW-1:0]           tail_cnt_q, tail_cnt_d;

  logic       busy_q, busy_d;
  logic [7:0] data_out_q, data_out_d;
  logic       data_valid_q, data_valid_d;
  logic       done_q, done_d;
  logic       sck_q, sck_d;
  logic       mosi_q, mosi_d;
  logic       cs_n_q, cs_n_d;

  // Next-state and registered-output logic; every pin is driven straight from a flop.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    rx_d         = rx_q;
    tail_cnt_d   = tail_cnt_q;
    busy_d       = busy_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    done_d       = 1'b0;
    sck_d        = sck_q;
    mosi_d       = mosi_q;
    cs_n_d       = cs_n_q;

    unique case (state_q)
      StIdle: begin
        if (start && (length != '0)) begin
          state_d    = StCmd;
          busy_d     = 1'b1;
          cs_n_d     = 1'b0;
          sck_d      = 1'b0;
          mosi_d     = CmdRead[7];
          shift_d    = {CmdRead[6:0], address, 1'b0};
          bit_cnt_d  = 5'd7;
          byte_cnt_d = length;
        end
      end

      StCmd: begin
        sck_d = ~sck_q;
        // sck_q high means this cycle closes the current bit; next bit starts low.
        if (sck_q) begin
          mosi_d  = shift_q[31];
          shift_d = {shift_q[30:0], 1'b0};
          if (bit_cnt_q == 5'd0) begin
            state_d   = StAddr;
            bit_cnt_d = 5'd23;
          end else begin
            bit_cnt_d = bit_cnt_q - 5'd1;
          end
        end
      end

      StAddr: begin
        sck_d = ~sck_q;
        if (sck_q) begin
          shift_d = {shift_q[30:0], 1'b0};
          if (bit_cnt_q == 5'd0) begin
            state_d   = StData;
            bit_cnt_d = 5'd7;
            mosi_d    = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q - 5'd1;
            mosi_d    = shift_q[31];
          end
        end
      end

      StData: begin
        sck_d = ~sck_q;
        if (sck_q) begin
          // The flash updates MISO on the falling edge, so it is stable here.
          rx_d   = {rx_q[6:0], flash_miso};
          mosi_d = 1'b0;
          if (bit_cnt_q == 5'd0) begin
            data_out_d   = {rx_q[6:0], flash_miso};
            data_valid_d = 1'b1;
            bit_cnt_d    = 5'd7;
            if (byte_cnt_q == LENGTH_BITWIDTH'(1)) begin
              state_d    = StTail;
              cs_n_d     = 1'b1;
              sck_d      = 1'b0;
              tail_cnt_d = TailW'(CS_HIGH_CYCLES - 1);
              done_d     = (CS_HIGH_CYCLES == 1);
            end else begin
              byte_cnt_d = byte_cnt_q - LENGTH_BITWIDTH'(1);
            end
          end else begin
            bit_cnt_d = bit_cnt_q - 5'd1;
          end
        end
      end

      StTail: begin
        // The tail starts in the final data_valid cycle; done marks its last cycle.
        if (tail_cnt_q == '0) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end else begin
          tail_cnt_d = tail_cnt_q - TailW'(1);
          done_d     = (tail_cnt_q == TailW'(1));
        end
      end

      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        cs_n_d  = 1'b1;
        sck_d   = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      rx_q         <= '0;
      tail_cnt_q   <= '0;
      busy_q       <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      done_q       <= 1'b0;
      sck_q        <= 1'b0;
      mosi_q       <= 1'b0;
      cs_n_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      rx_q         <= rx_d;
      tail_cnt_q   <= tail_cnt_d;
      busy_q       <= busy_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      done_q       <= done_d;
      sck_q        <= sck_d;
      mosi_q       <= mosi_d;
      cs_n_q       <= cs_n_d;
    end
  end

  assign busy       = busy_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign done       = done_q;
  assign flash_clk  = sck_q;
  assign flash_mosi = mosi_q;
  assign flash_cs_n = cs_n_q;

endmodule
